four2three_rd_ctrl: RTL and testbench

FOUR2THREE_RD_CTRL -- requirements
Module: four2three_rd_ctrl

---
 rtl/four2three_rd_ctrl_pkg.sv | 22 ++
 rtl/four2three_rd_ctrl_skid_buf2.sv | 64 ++++++
 rtl/four2three_rd_ctrl.sv | 128 ++++++++++++
 tb/tb_four2three_rd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/four2three_rd_ctrl_pkg.sv
// ============================================================================
// four2three_rd_ctrl_pkg : shared state encoding and constants for the reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package four2three_rd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // M_Ready lags the FIFO count by two edges after a row is consumed.
    localparam logic [1:0] C_GUARD_RELOAD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/four2three_rd_ctrl_skid_buf2.sv
// ============================================================================
// skid_buf2 : two-entry skid buffer with bypass, preserving order under stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module skid_buf2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   cnt_o,
    output logic [1:0]   cnt_next_o
);

    logic [W-1:0] e0_q, e1_q, e0_d, e1_d;
    logic [1:0]   cnt_q, cnt_d, wr_idx;
    logic         push, pop;

    // An arriving word bypasses storage only when nothing is held and it is taken.
    always_comb begin
        pop    = (cnt_q != 2'd0) && out_ready_i;
        push   = in_valid_i && !((cnt_q == 2'd0) && out_ready_i);
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_idx = cnt_q - {1'b0, pop};
        e0_d   = e0_q;
        e1_d   = e1_q;
        if (pop) begin
            e0_d = e1_q;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                e0_d = in_data_i;
            end else begin
                e1_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid_o = (cnt_q != 2'd0) || in_valid_i;
    assign out_data_o  = (cnt_q != 2'd0) ? e0_q : (in_valid_i ? in_data_i : '0);
    assign cnt_o       = cnt_q;
    assign cnt_next_o  = cnt_d;

endmodule

`default_nettype wire

// File: rtl/four2three_rd_ctrl.sv
// ============================================================================
// four2three_rd_ctrl : reads whole rows from a FIFO and streams them out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module four2three_rd_ctrl
    import four2three_rd_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   col_num,
    input  logic [ADDR_BITS:0]   row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 Next_Reg,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 row_last,
    output logic                 frame_done
);

    localparam int CW = ADDR_BITS + 1;

    state_t          state_q;
    logic [CW-1:0]   col_num_q, row_num_q, col_q, row_q;
    logic [1:0]      guard_q;
    logic            inflight_q, rd_last_q, done_q;

    logic [1:0]      skid_cnt, skid_cnt_next;
    logic [WIDTH:0]  skid_out;
    logic            end_of_row, last_row;

    // The read strobe must see this cycle's occupancy, so it is decoded, not registered.
    assign fifo_rd_en = (state_q == ST_READ) &&
                        (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2);
    assign end_of_row = fifo_rd_en && (col_q == (col_num_q - CW'(1)));
    assign last_row   = (row_q == (row_num_q - CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            col_num_q  <= '0;
            row_num_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            guard_q    <= 2'd0;
            inflight_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            rd_last_q  <= end_of_row;
            done_q     <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        col_num_q <= col_num;
                        row_num_q <= row_num;
                        col_q     <= '0;
                        row_q     <= '0;
                        guard_q   <= C_GUARD_RELOAD;
                        state_q   <= ((col_num == '0) || (row_num == '0)) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (guard_q != 2'd0) begin
                        guard_q <= guard_q - 2'd1;
                    end else if (M_Ready) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (end_of_row) begin
                        col_q   <= '0;
                        row_q   <= row_q + CW'(1);
                        guard_q <= C_GUARD_RELOAD;
                        state_q <= last_row ? ST_DRAIN : ST_WAIT;
                    end else if (fifo_rd_en) begin
                        col_q <= col_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    // No reads are issued here, so the skid's next count covers in-flight data.
                    if (skid_cnt_next == 2'd0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    skid_buf2 #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   ({rd_last_q, fifo_dout}),
        .out_ready_i (dout_ready),
        .out_valid_o (dout_valid),
        .out_data_o  (skid_out),
        .cnt_o       (skid_cnt),
        .cnt_next_o  (skid_cnt_next)
    );

    assign dout       = skid_out[WIDTH-1:0];
    assign row_last   = skid_out[WIDTH];
    assign M_count    = col_num_q;
    assign Next_Reg   = done_q;
    assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_four2three_rd_ctrl.sv
// ============================================================================
// tb_four2three_rd_ctrl : directed bench with a behavioural FIFO and stream monitor.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_four2three_rd_ctrl;

    localparam int WIDTH = 8;
    localparam int AB    = 10;
    localparam int CW    = AB + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CW-1:0]    col_num = '0;
    logic [CW-1:0]    row_num = '0;
    logic [CW-1:0]    M_count;
    logic             M_Ready = 1'b0;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             Next_Reg;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b1;
    logic             row_last;
    logic             frame_done;

    four2three_rd_ctrl #(.WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .col_num    (col_num),
        .row_num    (row_num),
        .M_count    (M_count),
        .M_Ready    (M_Ready),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .Next_Reg   (Next_Reg),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .row_last   (row_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Behavioural FIFO: one-cycle read data, registered count and flag.
    int fq[$];
    int dc = 0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        M_Ready <= (dc >= int'(M_count));
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= 8'(fq.pop_front());
        if (Next_Reg) fq.delete();
        dc <= fq.size();
    end

    // Stream monitor.
    logic [8:0] got[$];
    int   rd_cyc[$];
    int   rd_total, fd_cnt, nr_cnt, fd_cyc, last_v_cyc, outstanding;
    int   occ_err, stab_err, lat_err;
    logic lat_on = 1'b0;
    logic rd_prev, prev_v, prev_r;
    logic [8:0] prev_d;
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            if (outstanding >= 2) occ_err++;
            rd_total++;
            rd_cyc.push_back(cyc);
        end
        if (lat_on && rd_prev && !dout_valid) lat_err++;
        if (prev_v && !prev_r && !(dout_valid && ({row_last, dout} == prev_d))) stab_err++;
        if (dout_valid) last_v_cyc = cyc;
        if (dout_valid && dout_ready) got.push_back({row_last, dout});
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (Next_Reg) nr_cnt++;
        outstanding += (fifo_rd_en ? 1 : 0) - ((dout_valid && dout_ready) ? 1 : 0);
        rd_prev = fifo_rd_en;
        prev_v  = dout_valid;
        prev_r  = dout_ready;
        prev_d  = {row_last, dout};
    end

    // Back-pressure pattern 1,0,0,1 repeating.
    logic bp_mode = 1'b0;
    int   bp_idx  = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                dout_ready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
                bp_idx++;
            end
        end
    end

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        got.delete();
        rd_cyc.delete();
        rd_total = 0; fd_cnt = 0; nr_cnt = 0; fd_cyc = 0; last_v_cyc = 0;
        outstanding = 0; occ_err = 0; stab_err = 0; lat_err = 0;
        rd_prev = 1'b0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) fq.push_back((base + i) & 255);
    endtask

    int st_cyc;
    task automatic start_frame(input int c, input int r);
        @(negedge clk);
        col_num = CW'(c);
        row_num = CW'(r);
        start   = 1'b1;
        st_cyc  = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && fd_cnt == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check({tag, "_done"}, fd_cnt, 1);
    endtask

    task automatic wait_reads(input int n, input int budget);
        for (int i = 0; i < budget && rd_total < n; i++) @(negedge clk);
    endtask

    task automatic verify_stream(input string tag, input int n, input int cols, input int base);
        int bad;
        logic [8:0] exp_w;
        bad = 0;
        check({tag, "_cnt"}, got.size(), n);
        for (int i = 0; i < got.size(); i++) begin
            exp_w = {((i % cols) == (cols - 1)), 8'((base + i) & 255)};
            if (got[i] !== exp_w) bad++;
        end
        check({tag, "_words"}, bad, 0);
    endtask

    function automatic int outs_packed();
        return int'({fifo_rd_en, dout_valid, row_last, Next_Reg, frame_done}) +
               int'(dout) + int'(M_count);
    endfunction

    int w_cyc, gap;

    initial begin
        // Reset state.
        clear_mon();
        check("rst_outs", outs_packed(), 0);
        check("rst_m_count", int'(M_count), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4x3 frame, ready held high.
        clear_mon();
        preload(12, 16);
        lat_on = 1'b1;
        start_frame(4, 3);
        check("basic_m_count", int'(M_count), 4);
        col_num = CW'(7);
        row_num = CW'(1);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("ignored_start", int'(M_count), 4);
        wait_done("basic", 200);
        lat_on = 1'b0;
        verify_stream("basic", 12, 4, 16);
        check("basic_done_gap", fd_cyc - last_v_cyc, 2);
        check("basic_next_reg", nr_cnt, 1);
        check("basic_latency", lat_err, 0);
        check("basic_rate", (rd_cyc.size() > 3) ? rd_cyc[3] - rd_cyc[0] : -1, 3);

        // Same frame under 1,0,0,1 back-pressure.
        clear_mon();
        preload(12, 64);
        bp_idx  = 0;
        bp_mode = 1'b1;
        start_frame(4, 3);
        wait_done("bp", 400);
        bp_mode = 1'b0;
        dout_ready = 1'b1;
        verify_stream("bp", 12, 4, 64);
        check("bp_occupancy", occ_err, 0);
        check("bp_stable", stab_err, 0);

        // Exactly one row available: reader must stall until the next row lands.
        clear_mon();
        preload(8, 128);
        start_frame(8, 2);
        wait_reads(8, 100);
        repeat (20) @(negedge clk);
        check("stale_hold", rd_total, 8);
        w_cyc = cyc;
        preload(8, 136);
        wait_done("stale", 200);
        gap = (rd_cyc.size() > 8) ? rd_cyc[8] - w_cyc : -1;
        check("stale_resume", gap, 3);
        verify_stream("stale", 16, 8, 128);

        // Zero-size frames.
        clear_mon();
        start_frame(0, 3);
        wait_done("zero_col", 20);
        check("zero_col_gap", fd_cyc - st_cyc, 2);
        check("zero_col_reads", rd_total, 0);
        check("zero_col_next", nr_cnt, 1);
        clear_mon();
        start_frame(4, 0);
        wait_done("zero_row", 20);
        check("zero_row_reads", rd_total, 0);

        // Reset in the middle of row 2 of a 4x4 frame.
        clear_mon();
        fq.delete();
        preload(16, 160);
        start_frame(4, 4);
        wait_reads(6, 100);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outs", outs_packed(), 0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", fd_cnt + nr_cnt, 0);
        rst = 1'b1;
        fq.delete();
        clear_mon();
        preload(16, 192);
        start_frame(4, 4);
        wait_done("midrst", 300);
        verify_stream("midrst", 16, 4, 192);

        // Full-width row: 1024 words per row, two rows.
        clear_mon();
        preload(2048, 0);
        start_frame(1024, 2);
        wait_done("max", 5000);
        check("max_reads", rd_total, 2048);
        verify_stream("max", 2048, 1024, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
